voice_mixer: RTL and testbench
==============================

# voice_mixer

Parametrised polyphonic mixer for the synth datapath, sitting between the per-voice `sine_machine` generators and the PWM output stage. It snapshots NUM_VOICES unsigned voice samples on an internal sample-rate tick and scales each by a per-voice envelope. The envelope ramps toward the MIDI velocity on note-on and back to zero on note-off, so there are no clicks. The block then accumulates the voices one per cycle, shifts and saturates the sum, and emits one PCM sample per tick with a valid pulse.

## Interface
Parameters:
- NUM_VOICES, 5, number of voice channels (≥1)
- SAMPLE_W, 8, width of voice samples and of pcm_out (offset binary, midpoint 2^(SAMPLE_W-1))
- VEL_W, 8, velocity/envelope width
- SAMPLE_PERIOD, 4536, clk cycles per output sample; must be ≥ NUM_VOICES+4
- MIX_SHIFT, 2, arithmetic right shift applied to the voice sum
- ATTACK_STEP, 8, envelope increment per tick
- RELEASE_STEP, 4, envelope decrement per tick

Ports:
- clk_in  input  1  system clock; single clock domain
- rst_in  input  1  synchronous, active-high reset
- update_in  input  1  one-cycle pulse: new note set present on on_mask_in/velocity_in
- on_mask_in  input  NUM_VOICES  per-voice note-on bits
- velocity_in  input  NUM_VOICES x VEL_W  per-voice velocity (unpacked array)
- sample_in  input  NUM_VOICES x SAMPLE_W  per-voice unsigned sample (unpacked array)
- pcm_out  output  SAMPLE_W  mixed, saturated sample
- pcm_valid_out  output  1  one-cycle pulse when pcm_out updates
- clip_out  output  1  one-cycle pulse, coincident with pcm_valid_out, when saturation occurred
- busy_out  output  1  high while in ACCUM or FINISH
- voice_active_out  output  NUM_VOICES  bit v = (env[v]!=0) or (target[v]!=0)

## Operation
- Target latch: on update_in, for each v, target[v] = (on_mask_in[v] && velocity_in[v]!=0) ? velocity_in[v] : 0.
  - Velocity 0 with the on bit set counts as note-off.
  - update_in is accepted in any state. Targets only affect the next envelope step.
- Tick counter: counts 0..SAMPLE_PERIOD-1 and wraps. The tick fires when count==SAMPLE_PERIOD-1.
- States:
  - IDLE: on tick, snapshot all sample_in into samp_reg, clear acc, idx=0, go to ACCUM.
  - ACCUM: one voice per cycle.
    - c = samp_reg[idx] − 2^(SAMPLE_W-1), signed, SAMPLE_W+1 bits.
    - p = c × env[idx], signed.
    - acc += p >>> (VEL_W−1).
    - When idx==NUM_VOICES−1, go to FINISH.
  - FINISH (one cycle):
    - m = (acc >>> MIX_SHIFT) + 2^(SAMPLE_W-1).
    - pcm_out = clamp(m, 0, 2^SAMPLE_W−1). clip_out=1 if clamped.
    - pcm_valid_out=1.
    - Step every envelope: if env<target, env=min(env+ATTACK_STEP, target); if env>target, env=max(env−RELEASE_STEP, target).
    - Return to IDLE.
- Envelope arithmetic is computed VEL_W+1 bits wide, so there is no wrap.
- The accumulator is signed and wide enough that it never overflows: SAMPLE_W+VEL_W+1+clog2(NUM_VOICES) bits.
- Sample k uses the envelope values from before step k. Envelopes all start at 0, so the first tick after note-on outputs the midpoint.
- Inactive voices (env=0) contribute exactly 0.
- Reset:
  - pcm_out = 2^(SAMPLE_W-1).
  - pcm_valid_out, clip_out, busy_out = 0; voice_active_out = 0.
  - env, target, acc, tick counter = 0; state = IDLE.
  - Reset during ACCUM/FINISH aborts the sample with no valid pulse.

## Timing
- Tick occurs at cycle T. ACCUM runs T+1..T+NUM_VOICES. FINISH registers outputs at T+NUM_VOICES+1, so pcm_valid_out is high in cycle T+NUM_VOICES+2.
- Latency from tick to valid is NUM_VOICES+2 cycles.
- One valid pulse per SAMPLE_PERIOD cycles, steady state. pcm_out holds between pulses.
- The tick cannot recur while busy (parameter constraint).
- sample_in is only sampled in the tick cycle. Later changes do not affect the current sample.
- update_in coincident with FINISH: the new targets are used in that same envelope step.
- The first tick occurs SAMPLE_PERIOD cycles after reset deassertion.

## Test plan
Bench parameters: SAMPLE_PERIOD=16, NUM_VOICES=5, SAMPLE_W=8, VEL_W=8, MIX_SHIFT=2, unless noted.

- Reset: hold rst_in for 3 cycles → pcm_out=128, pcm_valid_out=0, voice_active_out=0, and the first valid pulse arrives 16+7 cycles after release.
- Single voice attack (ATTACK_STEP=127): update with mask=00001, vel0=127, sample0=255 → first valid pcm_out=128; second valid 126>>>2=31 → pcm_out=159; clip_out=0.
- Saturation (MIX_SHIFT=0, ATTACK_STEP=127): four voices at vel 127.
  - sample=255 → pcm_out=255 (128+504) with clip_out=1.
  - sample=0 → 4×(−127)+128 → pcm_out=0, clip_out=1.
- Release (ATTACK_STEP=127, RELEASE_STEP=32): voice0 env=127, then update mask=0 → env 95, 63, 31, 0 on successive ticks; voice_active_out[0] goes low after the fourth tick; pcm_out returns to 128.
- Mid-sample update: pulse update_in (mask=00010, vel1=0) during ACCUM → current pcm_out unchanged; voice_active_out[1] stays 0 (zero velocity means off); busy_out is high for exactly 6 cycles per tick.
- Reset mid-ACCUM: assert rst_in at ACCUM idx=2 → no pcm_valid_out for that tick, all outputs at reset values, and normal operation after SAMPLE_PERIOD.

Source files
------------

// File: rtl/voice_mixer.sv
// Polyphonic voice mixer: snapshots voice samples on a sample-rate tick, scales each
// by a click-free envelope, accumulates one voice per cycle and emits a saturated PCM sample.
module voice_mixer #(
    parameter int NUM_VOICES    = 5,
    parameter int SAMPLE_W      = 8,
    parameter int VEL_W         = 8,
    parameter int SAMPLE_PERIOD = 4536,
    parameter int MIX_SHIFT     = 2,
    parameter int ATTACK_STEP   = 8,
    parameter int RELEASE_STEP  = 4
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic                  update_in,
    input  logic [NUM_VOICES-1:0] on_mask_in,
    input  logic [VEL_W-1:0]      velocity_in [NUM_VOICES],
    input  logic [SAMPLE_W-1:0]   sample_in   [NUM_VOICES],
    output logic [SAMPLE_W-1:0]   pcm_out,
    output logic                  pcm_valid_out,
    output logic                  clip_out,
    output logic                  busy_out,
    output logic [NUM_VOICES-1:0] voice_active_out
);

    localparam int CNT_W  = (SAMPLE_PERIOD > 1) ? $clog2(SAMPLE_PERIOD) : 1;
    localparam int IDX_W  = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
    localparam int ACC_W  = SAMPLE_W + VEL_W + 1 + $clog2(NUM_VOICES);
    localparam int PROD_W = SAMPLE_W + VEL_W + 2;

    localparam logic [CNT_W-1:0]        LAST_CNT = CNT_W'(SAMPLE_PERIOD - 1);
    localparam logic [IDX_W-1:0]        LAST_IDX = IDX_W'(NUM_VOICES - 1);
    localparam logic [SAMPLE_W-1:0]     MID_U    = SAMPLE_W'(2 ** (SAMPLE_W - 1));
    localparam logic signed [ACC_W:0]   MID_S    = (ACC_W + 1)'(2 ** (SAMPLE_W - 1));
    localparam logic signed [ACC_W:0]   MAX_S    = (ACC_W + 1)'(2 ** SAMPLE_W - 1);
    localparam logic signed [ACC_W:0]   ZERO_S   = '0;
    localparam logic [VEL_W:0]          ATT_E    = (VEL_W + 1)'(ATTACK_STEP);
    localparam logic [VEL_W:0]          REL_E    = (VEL_W + 1)'(RELEASE_STEP);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCUM  = 2'd1,
        ST_FINISH = 2'd2
    } state_t;

    state_t                     state_r, state_nxt;
    logic [CNT_W-1:0]           cnt_r;
    logic [IDX_W-1:0]           idx_r;
    logic signed [ACC_W-1:0]    acc_r, acc_nxt;
    logic [SAMPLE_W-1:0]        samp_r   [NUM_VOICES];
    logic [VEL_W-1:0]           env_r    [NUM_VOICES];
    logic [VEL_W-1:0]           env_nxt  [NUM_VOICES];
    logic [VEL_W-1:0]           target_r [NUM_VOICES];
    logic [VEL_W-1:0]           target_nxt [NUM_VOICES];
    logic [SAMPLE_W-1:0]        pcm_r, pcm_s;
    logic                       valid_r, clip_r, clip_s, busy_r, busy_nxt;
    logic [NUM_VOICES-1:0]      active_r, active_nxt;
    logic                       tick_s;
    logic signed [SAMPLE_W:0]   centred_s;
    logic signed [VEL_W:0]      gain_s;
    logic signed [PROD_W-1:0]   prod_s;
    logic signed [ACC_W-1:0]    shifted_s;
    logic signed [ACC_W:0]      mix_s;

    assign tick_s = (cnt_r == LAST_CNT);

    // State register
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state_r;
        case (state_r)
            ST_IDLE:   state_nxt = tick_s ? ST_ACCUM : ST_IDLE;
            ST_ACCUM:  state_nxt = (idx_r == LAST_IDX) ? ST_FINISH : ST_ACCUM;
            ST_FINISH: state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    // Datapath and output next values: MAC, saturating mix, envelope step, status flags
    always_comb begin
        centred_s = $signed({1'b0, samp_r[idx_r]}) - $signed({1'b0, MID_U});
        gain_s    = $signed({1'b0, env_r[idx_r]});
        prod_s    = PROD_W'(centred_s) * PROD_W'(gain_s);
        acc_nxt   = acc_r + ACC_W'(prod_s >>> (VEL_W - 1));

        shifted_s = acc_r >>> MIX_SHIFT;
        mix_s     = (ACC_W + 1)'(shifted_s) + MID_S;
        if (mix_s < ZERO_S) begin
            pcm_s  = '0;
            clip_s = 1'b1;
        end else if (mix_s > MAX_S) begin
            pcm_s  = '1;
            clip_s = 1'b1;
        end else begin
            pcm_s  = mix_s[SAMPLE_W-1:0];
            clip_s = 1'b0;
        end

        // New targets land before the envelope step so a FINISH-cycle update is honoured
        for (int v = 0; v < NUM_VOICES; v++) begin
            if (update_in) begin
                target_nxt[v] = (on_mask_in[v] && (velocity_in[v] != '0)) ? velocity_in[v] : '0;
            end else begin
                target_nxt[v] = target_r[v];
            end

            if ((state_r == ST_FINISH) && (env_r[v] < target_nxt[v])) begin
                if (({1'b0, env_r[v]} + ATT_E) >= {1'b0, target_nxt[v]}) begin
                    env_nxt[v] = target_nxt[v];
                end else begin
                    env_nxt[v] = env_r[v] + VEL_W'(ATTACK_STEP);
                end
            end else if ((state_r == ST_FINISH) && (env_r[v] > target_nxt[v])) begin
                if ({1'b0, env_r[v]} <= ({1'b0, target_nxt[v]} + REL_E)) begin
                    env_nxt[v] = target_nxt[v];
                end else begin
                    env_nxt[v] = env_r[v] - VEL_W'(RELEASE_STEP);
                end
            end else begin
                env_nxt[v] = env_r[v];
            end

            active_nxt[v] = (env_nxt[v] != '0) || (target_nxt[v] != '0);
        end

        busy_nxt = (state_nxt != ST_IDLE);
    end

    // Tick counter, sample snapshot, accumulator and envelope registers
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            cnt_r <= '0;
            idx_r <= '0;
            acc_r <= '0;
            for (int v = 0; v < NUM_VOICES; v++) begin
                samp_r[v]   <= '0;
                env_r[v]    <= '0;
                target_r[v] <= '0;
            end
        end else begin
            cnt_r <= tick_s ? '0 : cnt_r + CNT_W'(1);
            if ((state_r == ST_IDLE) && tick_s) begin
                idx_r  <= '0;
                acc_r  <= '0;
                samp_r <= sample_in;
            end else if (state_r == ST_ACCUM) begin
                idx_r <= idx_r + IDX_W'(1);
                acc_r <= acc_nxt;
            end else begin
                idx_r <= idx_r;
                acc_r <= acc_r;
            end
            env_r    <= env_nxt;
            target_r <= target_nxt;
        end
    end

    // Output registers
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            pcm_r    <= MID_U;
            valid_r  <= 1'b0;
            clip_r   <= 1'b0;
            busy_r   <= 1'b0;
            active_r <= '0;
        end else begin
            valid_r  <= (state_r == ST_FINISH);
            clip_r   <= (state_r == ST_FINISH) && clip_s;
            pcm_r    <= (state_r == ST_FINISH) ? pcm_s : pcm_r;
            busy_r   <= busy_nxt;
            active_r <= active_nxt;
        end
    end

    assign pcm_out          = pcm_r;
    assign pcm_valid_out    = valid_r;
    assign clip_out         = clip_r;
    assign busy_out         = busy_r;
    assign voice_active_out = active_r;

endmodule

// File: tb/tb_voice_mixer.sv
// Self-checking bench for voice_mixer: two instances (MIX_SHIFT 2 and 0) against a
// per-tick arithmetic reference model, with directed scenarios followed by random stimulus.
module tb_voice_mixer;

    localparam int NV  = 5;
    localparam int SW  = 8;
    localparam int VW  = 8;
    localparam int SP  = 16;
    localparam int ATT = 127;
    localparam int REL = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          upd;
    logic [NV-1:0] mask;
    logic [VW-1:0] vel [NV];
    logic [SW-1:0] smp [NV];
    logic [SW-1:0] pcm_a, pcm_b;
    logic          val_a, val_b, clip_a, clip_b, busy_a, busy_b;
    logic [NV-1:0] act_a, act_b;

    always #5 clk = ~clk;

    voice_mixer #(.NUM_VOICES(NV), .SAMPLE_W(SW), .VEL_W(VW), .SAMPLE_PERIOD(SP),
                  .MIX_SHIFT(2), .ATTACK_STEP(ATT), .RELEASE_STEP(REL)) dut_a (
        .clk_in(clk), .rst_in(rst), .update_in(upd), .on_mask_in(mask),
        .velocity_in(vel), .sample_in(smp), .pcm_out(pcm_a), .pcm_valid_out(val_a),
        .clip_out(clip_a), .busy_out(busy_a), .voice_active_out(act_a));

    voice_mixer #(.NUM_VOICES(NV), .SAMPLE_W(SW), .VEL_W(VW), .SAMPLE_PERIOD(SP),
                  .MIX_SHIFT(0), .ATTACK_STEP(ATT), .RELEASE_STEP(REL)) dut_b (
        .clk_in(clk), .rst_in(rst), .update_in(upd), .on_mask_in(mask),
        .velocity_in(vel), .sample_in(smp), .pcm_out(pcm_b), .pcm_valid_out(val_b),
        .clip_out(clip_b), .busy_out(busy_b), .voice_active_out(act_b));

    int checks = 0;
    int errors = 0;

    // reference model state
    int m_env [NV];
    int m_tgt [NV];
    int m_cnt, m_fin, m_valid;
    int m_pcm [2];
    int m_clip [2];
    int m_pend_pcm [2];
    int m_pend_clip [2];

    int last_pcm [2];
    int last_clip [2];

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic void mix(input int shift, output int pcm, output int clip);
        int acc = 0;
        int m;
        for (int v = 0; v < NV; v++) begin
            acc += ((int'(smp[v]) - 128) * m_env[v]) >>> (VW - 1);
        end
        m = (acc >>> shift) + 128;
        clip = (m < 0 || m > 255) ? 1 : 0;
        pcm  = (m < 0) ? 0 : (m > 255) ? 255 : m;
    endfunction

    // what the coming clock edge does, from the current inputs
    task automatic model_edge();
        int tgt_eff [NV];
        if (rst) begin
            for (int v = 0; v < NV; v++) begin
                m_env[v] = 0;
                m_tgt[v] = 0;
            end
            m_cnt = 0; m_fin = 0; m_valid = 0;
            for (int d = 0; d < 2; d++) begin
                m_pcm[d] = 128;
                m_clip[d] = 0;
            end
            return;
        end
        for (int v = 0; v < NV; v++) begin
            tgt_eff[v] = upd ? ((mask[v] && vel[v] != 0) ? int'(vel[v]) : 0) : m_tgt[v];
        end
        m_valid = 0;
        if (m_fin == 1) begin
            m_valid = 1;
            for (int d = 0; d < 2; d++) begin
                m_pcm[d]  = m_pend_pcm[d];
                m_clip[d] = m_pend_clip[d];
            end
            for (int v = 0; v < NV; v++) begin
                if (m_env[v] < tgt_eff[v])
                    m_env[v] = (m_env[v] + ATT > tgt_eff[v]) ? tgt_eff[v] : m_env[v] + ATT;
                else if (m_env[v] > tgt_eff[v])
                    m_env[v] = (m_env[v] - REL < tgt_eff[v]) ? tgt_eff[v] : m_env[v] - REL;
            end
        end
        if (m_fin > 0) m_fin--;
        if (m_cnt == SP - 1) begin
            mix(2, m_pend_pcm[0], m_pend_clip[0]);
            mix(0, m_pend_pcm[1], m_pend_clip[1]);
            m_fin = 6;
            m_cnt = 0;
        end else begin
            m_cnt++;
        end
        for (int v = 0; v < NV; v++) m_tgt[v] = tgt_eff[v];
    endtask

    task automatic step();
        int act;
        model_edge();
        @(posedge clk);
        #1;
        upd = 1'b0;
        act = 0;
        for (int v = 0; v < NV; v++)
            if (m_env[v] != 0 || m_tgt[v] != 0) act |= (1 << v);
        check_val("valid_a", val_a, m_valid);
        check_val("valid_b", val_b, m_valid);
        check_val("pcm_a", pcm_a, m_pcm[0]);
        check_val("pcm_b", pcm_b, m_pcm[1]);
        check_val("clip_a", clip_a, m_valid ? m_clip[0] : 0);
        check_val("clip_b", clip_b, m_valid ? m_clip[1] : 0);
        check_val("busy_a", busy_a, (m_fin > 0) ? 1 : 0);
        check_val("active_a", act_a, act);
        check_val("active_b", act_b, act);
        if (val_a) begin
            last_pcm[0] = pcm_a;
            last_clip[0] = clip_a;
        end
        if (val_b) begin
            last_pcm[1] = pcm_b;
            last_clip[1] = clip_b;
        end
    endtask

    task automatic wait_valid(input string tag);
        int k = 0;
        do begin
            step();
            k++;
        end while (!val_a && k < 3 * SP);
        if (!val_a) check_val(tag, val_a, 1);
    endtask

    task automatic run_to_phase(input int ph);
        int k = 0;
        while (m_cnt != ph && k < 2 * SP) begin
            step();
            k++;
        end
    endtask

    task automatic set_samples(input int s0, input int s_rest);
        smp[0] = SW'(s0);
        for (int v = 1; v < NV; v++) smp[v] = SW'(s_rest);
    endtask

    initial begin
        int k;
        int busy_cnt;
        rst = 1'b1; upd = 1'b0; mask = '0;
        for (int v = 0; v < NV; v++) begin
            vel[v] = '0;
            smp[v] = 8'd128;
        end

        // reset held three cycles, then first valid pulse timing
        repeat (3) step();
        check_val("reset_pcm", pcm_a, 128);
        check_val("reset_active", act_a, 0);
        rst = 1'b0;
        k = 1;
        do begin
            step();
            k++;
        end while (!val_a && k < 60);
        check_val("first_valid_cycle", k, SP + NV + 2);

        // single voice attack
        set_samples(255, 128);
        mask = 5'b00001; vel[0] = 8'd127; upd = 1'b1;
        step();
        wait_valid("attack_timeout1");
        check_val("attack_first_pcm", last_pcm[0], 128);
        wait_valid("attack_timeout2");
        check_val("attack_second_pcm", last_pcm[0], 159);
        check_val("attack_clip", last_clip[0], 0);

        // saturation on the unshifted instance
        for (int v = 0; v < 4; v++) begin
            smp[v] = 8'd255;
            vel[v] = 8'd127;
        end
        mask = 5'b01111; upd = 1'b1;
        step();
        wait_valid("sat_timeout1");
        wait_valid("sat_timeout2");
        check_val("sat_high_pcm", last_pcm[1], 255);
        check_val("sat_high_clip", last_clip[1], 1);
        for (int v = 0; v < 4; v++) smp[v] = 8'd0;
        wait_valid("sat_timeout3");
        check_val("sat_low_pcm", last_pcm[1], 0);
        check_val("sat_low_clip", last_clip[1], 1);

        // release: 127 -> 95 -> 63 -> 31 -> 0
        set_samples(255, 128);
        mask = '0; upd = 1'b1;
        step();
        for (int i = 0; i < 3; i++) wait_valid("rel_timeout");
        check_val("rel_active_before", act_a[0], 1);
        wait_valid("rel_timeout4");
        check_val("rel_active_after", act_a[0], 0);
        wait_valid("rel_timeout5");
        check_val("rel_pcm_mid", last_pcm[0], 128);

        // update during ACCUM with zero velocity; busy width per tick
        set_samples(200, 60);
        mask = 5'b00001; vel[0] = 8'd100; upd = 1'b1;
        step();
        wait_valid("mid_timeout1");
        run_to_phase(2);
        mask = 5'b00010; vel[1] = 8'd0; upd = 1'b1;
        step();
        busy_cnt = 0;
        for (int i = 0; i < SP; i++) begin
            step();
            if (busy_a) busy_cnt++;
        end
        check_val("busy_width", busy_cnt, 6);
        check_val("mid_active1", act_a[1], 0);

        // reset in the middle of ACCUM aborts the sample
        mask = 5'b00011; vel[0] = 8'd90; vel[1] = 8'd200; upd = 1'b1;
        step();
        wait_valid("rst_timeout1");
        run_to_phase(2);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_val("rst_mid_pcm", pcm_a, 128);
        check_val("rst_mid_busy", busy_a, 0);
        wait_valid("rst_recover_timeout");

        // random stimulus
        for (int i = 0; i < 40 * SP; i++) begin
            for (int v = 0; v < NV; v++) smp[v] = SW'($urandom_range(0, 255));
            if ($urandom_range(0, 7) == 0) begin
                mask = NV'($urandom);
                for (int v = 0; v < NV; v++)
                    vel[v] = ($urandom_range(0, 3) == 0) ? 8'd0 : VW'($urandom_range(1, 255));
                upd = 1'b1;
            end
            if ($urandom_range(0, 299) == 0) rst = 1'b1;
            step();
            rst = 1'b0;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
